// File: rtl/gpio_pkg.sv
// Shared constants and per-channel debounce state for the GPIO input banks.
// The counter field is sized for the widest legal tick-count width so one typedef serves every instance.
package gpio_pkg;

  localparam int GPIO_PRESCALE  = 50;
  localparam int GPIO_CNT_W     = 8;
  localparam int GPIO_CNT_MAX_W = 16;
  localparam int GPIO_IN1_WIDTH = 22;
  localparam int GPIO_IN2_WIDTH = 17;

  typedef struct packed {
    logic                      filt;
    logic [GPIO_CNT_MAX_W-1:0] cnt;
  } deb_state_t;

  // True when the tick being counted now reaches the stable-time threshold.
  function automatic logic deb_expired(input logic [GPIO_CNT_MAX_W-1:0] cnt,
                                       input logic [GPIO_CNT_MAX_W-1:0] thr);
    return ({1'b0, cnt} + {{GPIO_CNT_MAX_W{1'b0}}, 1'b1}) >= {1'b0, thr};
  endfunction

endpackage

// File: rtl/gpio_debounce_ch.sv
// One input channel: 2-flop synchroniser, tick-based debounce counter, filtered flop.
// Raw to filt: 3 cycles in bypass; rise/fall pulses are combinational, coincident with the filt update.
module gpio_debounce_ch
  import gpio_pkg::*;
#(
  parameter int   CNT_W     = GPIO_CNT_W,
  parameter logic RESET_BIT = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             raw_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] ticks_i,
  output logic             filt_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic                      sync1_q;
  logic                      sync2_q;
  deb_state_t                st_q;
  deb_state_t                st_d;
  logic [GPIO_CNT_MAX_W-1:0] thr;
  logic                      upd;

  assign thr = GPIO_CNT_MAX_W'(ticks_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= RESET_BIT;
      sync2_q <= RESET_BIT;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q.filt <= RESET_BIT;
      st_q.cnt  <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  // Any return to agreement clears the count, so a bounce restarts the window.
  always_comb begin
    st_d = st_q;
    upd  = 1'b0;
    if (sync2_q == st_q.filt) begin
      st_d.cnt = '0;
    end else if (thr == '0) begin
      upd = 1'b1;
    end else if (tick_i) begin
      if (deb_expired(st_q.cnt, thr)) begin
        upd = 1'b1;
      end else begin
        st_d.cnt = st_q.cnt + GPIO_CNT_MAX_W'(1);
      end
    end
    if (upd) begin
      st_d.filt = sync2_q;
      st_d.cnt  = '0;
    end
  end

  assign filt_o = st_q.filt;
  assign rise_o = upd & sync2_q;
  assign fall_o = upd & ~sync2_q;

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: per-channel sync + debounce, sticky edge events, maskable registered IRQ.
// Raw to FILT_OUT/events 3 cycles in bypass, IRQ one cycle after that; events clear by write-1 strobe.
module gpio_in_filter
  import gpio_pkg::*;
#(
  parameter int               WIDTH     = GPIO_IN1_WIDTH,
  parameter int               PRESCALE  = GPIO_PRESCALE,
  parameter int               CNT_W     = GPIO_CNT_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             OPB_CLK,
  input  logic             OPB_RST_N,
  input  logic [WIDTH-1:0] RAW_IN,
  input  logic [CNT_W-1:0] DEBOUNCE_TICKS,
  input  logic [WIDTH-1:0] IRQ_MASK,
  input  logic             EVT_CLR_WE,
  input  logic [WIDTH-1:0] EVT_CLR,
  output logic [WIDTH-1:0] FILT_OUT,
  output logic [WIDTH-1:0] EVT_RISE,
  output logic [WIDTH-1:0] EVT_FALL,
  output logic             IRQ
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0]      pre_q;
  logic [15:0]      pre_d;
  logic             tick;
  logic [WIDTH-1:0] rise_p;
  logic [WIDTH-1:0] fall_p;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic             irq_q;
  logic             irq_d;

  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = tick ? 16'd0 : pre_q + 16'd1;

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    gpio_debounce_ch #(
      .CNT_W     (CNT_W),
      .RESET_BIT (RESET_VAL[g])
    ) u_ch (
      .clk_i   (OPB_CLK),
      .rst_ni  (OPB_RST_N),
      .raw_i   (RAW_IN[g]),
      .tick_i  (tick),
      .ticks_i (DEBOUNCE_TICKS),
      .filt_o  (FILT_OUT[g]),
      .rise_o  (rise_p[g]),
      .fall_o  (fall_p[g])
    );
  end

  // OR-ing the new pulses after the clear lets a same-cycle set win over the clear.
  assign clr_mask = EVT_CLR_WE ? EVT_CLR : '0;
  assign rise_d   = (rise_q & ~clr_mask) | rise_p;
  assign fall_d   = (fall_q & ~clr_mask) | fall_p;
  assign irq_d    = |((rise_q | fall_q) & IRQ_MASK);

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      rise_q <= '0;
      fall_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      irq_q  <= irq_d;
    end
  end

  assign EVT_RISE = rise_q;
  assign EVT_FALL = fall_q;
  assign IRQ      = irq_q;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter with a cycle-level behavioural model checked every negedge.
module tb_gpio_in_filter;

  localparam int          W   = 22;
  localparam int          PS  = 4;
  localparam logic [21:0] RST = 22'h000080;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  raw;
  logic [7:0]    ticks;
  logic [W-1:0]  mask;
  logic          we;
  logic [W-1:0]  clr;
  logic [W-1:0]  filt;
  logic [W-1:0]  rise;
  logic [W-1:0]  fall;
  logic          irq;

  int n_checks = 0;
  int n_errs   = 0;

  gpio_in_filter #(
    .WIDTH     (W),
    .PRESCALE  (PS),
    .CNT_W     (8),
    .RESET_VAL (RST)
  ) dut (
    .OPB_CLK        (clk),
    .OPB_RST_N      (rst_n),
    .RAW_IN         (raw),
    .DEBOUNCE_TICKS (ticks),
    .IRQ_MASK       (mask),
    .EVT_CLR_WE     (we),
    .EVT_CLR        (clr),
    .FILT_OUT       (filt),
    .EVT_RISE       (rise),
    .EVT_FALL       (fall),
    .IRQ            (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: sync value is the raw input two edges back; elapsed[] counts ticks spent in disagreement.
  logic [W-1:0] m_filt, m_rise, m_fall, hist1, hist2;
  logic [W-1:0] set_r, set_f, clr_v;
  logic         m_irq, tk, nirq;
  int           n_edge;
  int           elapsed [W];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_filt = RST; m_rise = '0; m_fall = '0; m_irq = 1'b0;
      hist1 = RST; hist2 = RST; n_edge = 0;
      for (int i = 0; i < W; i++) elapsed[i] = 0;
    end else begin
      tk    = (n_edge % PS) == PS - 1;
      nirq  = |((m_rise | m_fall) & mask);
      set_r = '0;
      set_f = '0;
      for (int i = 0; i < W; i++) begin
        if (hist2[i] == m_filt[i]) begin
          elapsed[i] = 0;
        end else if (ticks == 8'd0 || (tk && elapsed[i] + 1 >= int'(ticks))) begin
          set_r[i]   = hist2[i];
          set_f[i]   = ~hist2[i];
          elapsed[i] = 0;
        end else if (tk) begin
          elapsed[i] = elapsed[i] + 1;
        end
      end
      m_filt = (m_filt & ~(set_r | set_f)) | set_r;
      clr_v  = we ? clr : '0;
      m_rise = (m_rise & ~clr_v) | set_r;
      m_fall = (m_fall & ~clr_v) | set_f;
      m_irq  = nirq;
      hist2  = hist1;
      hist1  = raw;
      n_edge = n_edge + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-computed expectation applied to both the DUT and the model.
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] mdl,
                     input logic [31:0] exp);
    chk(name, act, exp);
    chk({name, "_model"}, mdl, exp);
  endtask

  always @(negedge clk) begin
    chk("filt", 32'(filt), 32'(m_filt));
    chk("rise", 32'(rise), 32'(m_rise));
    chk("fall", 32'(fall), 32'(m_fall));
    chk("irq",  32'(irq),  32'(m_irq));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_all();
    we = 1'b1; clr = '1;
    step(1);
    we = 1'b0; clr = '0;
  endtask

  task automatic reset_seq(input string tag);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      raw = 22'($urandom);
      step(1);
    end
    lit({tag, "_filt"}, 32'(filt), 32'(m_filt), 32'(RST));
    lit({tag, "_rise"}, 32'(rise), 32'(m_rise), 32'd0);
    lit({tag, "_fall"}, 32'(fall), 32'(m_fall), 32'd0);
    lit({tag, "_irq"},  32'(irq),  32'(m_irq),  32'd0);
    raw = RST;
    step(1);
    rst_n = 1'b1;
    step(100);
    lit({tag, "_quiet_rise"}, 32'(rise), 32'(m_rise), 32'd0);
    lit({tag, "_quiet_fall"}, 32'(fall), 32'(m_fall), 32'd0);
    lit({tag, "_quiet_filt"}, 32'(filt), 32'(m_filt), 32'(RST));
  endtask

  initial begin
    rst_n = 1'b1; raw = RST; ticks = 8'd0; mask = '0; we = 1'b0; clr = '0;
    #1;
    reset_seq("reset");

    // Bypass: filt/event 3 edges after the raw change, IRQ one edge later.
    ticks = 8'd0; mask = 22'h1;
    raw[0] = 1'b1;
    step(2);
    lit("byp_filt_early", 32'(filt[0]), 32'(m_filt[0]), 32'd0);
    step(1);
    lit("byp_filt", 32'(filt[0]), 32'(m_filt[0]), 32'd1);
    lit("byp_rise", 32'(rise[0]), 32'(m_rise[0]), 32'd1);
    lit("byp_irq_early", 32'(irq), 32'(m_irq), 32'd0);
    step(1);
    lit("byp_irq", 32'(irq), 32'(m_irq), 32'd1);
    clear_all();

    // Glitch: a 5-cycle pulse spans at most 2 ticks, so threshold 3 rejects it.
    ticks = 8'd3;
    raw[5] = 1'b1;
    step(5);
    raw[5] = 1'b0;
    step(20);
    lit("glitch_filt", 32'(filt[5]), 32'(m_filt[5]), 32'd0);
    lit("glitch_rise", 32'(rise[5]), 32'(m_rise[5]), 32'd0);
    raw[5] = 1'b1;
    step(10);
    lit("hold_filt_early", 32'(filt[5]), 32'(m_filt[5]), 32'd0);
    step(5);
    lit("hold_filt", 32'(filt[5]), 32'(m_filt[5]), 32'd1);
    lit("hold_rise", 32'(rise[5]), 32'(m_rise[5]), 32'd1);

    // Bounce: 8 cycles high (exactly 2 ticks), 1 cycle low, high again.
    raw[9] = 1'b1;
    step(8);
    raw[9] = 1'b0;
    step(1);
    raw[9] = 1'b1;
    step(10);
    lit("bounce_filt_early", 32'(filt[9]), 32'(m_filt[9]), 32'd0);
    step(5);
    lit("bounce_filt", 32'(filt[9]), 32'(m_filt[9]), 32'd1);

    // Clear collision on channel 2 in bypass mode.
    ticks = 8'd0; mask = 22'h4;
    clear_all();
    raw[2] = 1'b1;
    step(4);
    raw[2] = 1'b0;
    step(4);
    lit("fall2_set", 32'(fall[2]), 32'(m_fall[2]), 32'd1);
    raw[2] = 1'b1;
    step(4);
    raw[2] = 1'b0;
    step(2);
    we = 1'b1; clr = 22'h4;
    step(1);
    we = 1'b0; clr = '0;
    lit("coll_fall", 32'(fall[2]), 32'(m_fall[2]), 32'd1);
    lit("coll_rise", 32'(rise[2]), 32'(m_rise[2]), 32'd0);
    lit("coll_filt", 32'(filt[2]), 32'(m_filt[2]), 32'd0);
    step(1);
    we = 1'b1; clr = 22'h4;
    step(1);
    we = 1'b0; clr = '0;
    lit("clr_fall", 32'(fall[2]), 32'(m_fall[2]), 32'd0);
    lit("clr_irq_lag", 32'(irq), 32'(m_irq), 32'd1);
    step(1);
    lit("clr_irq", 32'(irq), 32'(m_irq), 32'd0);

    // Threshold lowered mid-count: the next tick completes the update.
    ticks = 8'd200;
    raw[12] = 1'b1;
    step(45);
    lit("thr_filt_early", 32'(filt[12]), 32'(m_filt[12]), 32'd0);
    ticks = 8'd5;
    step(4);
    lit("thr_filt", 32'(filt[12]), 32'(m_filt[12]), 32'd1);

    // Reset in the middle of a count.
    raw[15] = 1'b1;
    step(10);
    reset_seq("midrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
